word_packer: RTL and testbench
==============================

# word_packer

Packs a stream of narrow chunks (e.g. 2-bit RMII receive dibits) into full-width words, least-significant chunk first, and emits each word with a single-cycle strobe. It sits directly upstream of `single_word_buffer`: `outclk`/`out` drive that buffer's `inclk`/`in`. It also supports a flush that emits a zero-padded partial word at end of frame, and a clear that realigns chunk boundaries at start of frame.

## Interface

- `IN_WIDTH`, default 2: chunk width in bits.
- `OUT_WIDTH`, default 8: word width in bits. It must be an integer multiple of `IN_WIDTH`.
- `RATIO`, derived as `OUT_WIDTH/IN_WIDTH`: chunks per word. It must be at least 2.
- `clk`, input, 1: system clock. There is one clock.
- `rst`, input, 1: synchronous, active-high reset.
- `inclk`, input, 1: qualifies `in` for one cycle. It is a data-valid strobe, not a clock.
- `in`, input, `IN_WIDTH`: chunk data, sampled when `inclk` = 1.
- `flush`, input, 1: emits the current partial word, if any.
- `clear`, input, 1: discards the partial word and realigns to chunk 0.
- `outclk`, output, 1: one-cycle strobe; `out`/`out_len` are valid this cycle.
- `out`, output, `OUT_WIDTH`: packed word. Chunk k occupies bits `[k*IN_WIDTH +: IN_WIDTH]`.
- `out_len`, output, `clog2(RATIO+1)`: number of valid chunks in `out`, from 1 to `RATIO`.
- `busy`, output, 1: high while a partial word is held (chunk count ≠ 0).

## Operation

- **Internal state:** shift/assembly register `acc[OUT_WIDTH-1:0]` and chunk counter `cnt` (0..RATIO-1). The state is implicit: cnt = 0 means EMPTY; cnt > 0 means PARTIAL.
- **Priority:** `rst` > `clear` > `inclk`/`flush`.
- **`rst`:**
  - `cnt`=0, `acc`=0.
  - `outclk`=0, `out`=0, `out_len`=0, `busy`=0.
- **`clear` without `inclk`:** `cnt`←0 and `acc`←0. No `outclk`.
- **`clear` with `inclk`:** the partial word is discarded. `in` becomes chunk 0 of a new word: `acc`←{0, `in`}, `cnt`←1.
- **`flush` is ignored when `clear` is high.**
- **`inclk` (no clear):** write `in` into `acc` chunk slot `cnt`.
  - If `cnt` = RATIO-1, emit the full word with `out_len`=RATIO, then `cnt`←0 and `acc`←0.
  - Otherwise `cnt`←`cnt`+1.
- **`flush` without `inclk`:**
  - If `cnt` > 0, emit `acc` with unfilled upper chunks = 0 and `out_len`=`cnt`. Then `cnt`←0 and `acc`←0.
  - If `cnt` = 0, there is no emit.
- **`flush` with `inclk`:** the chunk is accepted first. Then emit with `out_len`=`cnt`+1 and reset `cnt`. This gives exactly one emit, including the case where the chunk completes the word.
- **Emit:** registers `out`/`out_len` and pulses `outclk` for exactly one cycle.
  - `out` and `out_len` hold their value until the next emit. They are not cleared on `outclk` deassert or on `clear`.
- **`busy`:** equals (`cnt` ≠ 0), registered with `cnt`.

## Timing

- **Latency:** `outclk` is asserted the cycle after the `inclk` or `flush` edge that triggers the emit (1-cycle registered latency). `out` and `out_len` are valid in the same cycle as `outclk`.
- **Throughput:** `inclk` may be asserted every cycle. With continuous input, `outclk` pulses once every RATIO cycles, and no chunk is dropped.
- **Back-to-back words:** a chunk arriving in the cycle `outclk` is high is accepted as chunk 0 of the next word.
- **Gaps:** any number of idle cycles between chunks is allowed; `acc` and `cnt` hold.
- **`busy` timing:** `busy` rises the cycle after the first chunk of a word. It falls in the same cycle `outclk` rises.
- **Reset mid-word:** the partial data is lost, no `outclk` follows, and all outputs are 0 the next cycle.

## Test plan

All scenarios use `IN_WIDTH`=2, `OUT_WIDTH`=8.

- **Full word:** reset, then dibits 01,10,11,00 on consecutive cycles. Expect `outclk` one cycle after the 4th chunk, `out`=8'h39, `out_len`=4, and `outclk` high for exactly 1 cycle.
- **Streaming:** continuous `inclk` for 12 cycles with dibits 11. Expect 3 `outclk` pulses spaced 4 cycles apart, each with `out`=8'hFF and `out_len`=4, and `busy` toggling as specified.
- **Flush of a partial word:**
  - Dibits 11,11,01, then `flush` alone. Expect `out`=8'h1F, `out_len`=3, one pulse.
  - A further `flush` with `cnt`=0 gives no pulse, and `out` stays 8'h1F.
- **Flush together with the completing chunk:** 3 chunks, then the 4th chunk with `flush` high in the same cycle. Expect a single `outclk` with `out_len`=4 and no second pulse.
- **Clear:**
  - 2 chunks, then `clear`+`inclk` with `in`=10, then 3 more chunks 00. Expect one word with `out`=8'h02 and `out_len`=4.
  - `clear`+`flush` with no `inclk` gives no pulse.
- **Reset mid-word:** 3 chunks, then `rst` for 1 cycle, then 4 chunks of 01. Expect no emit of the partial word, then `out`=8'h55 with `out_len`=4. `outclk`, `out` and `busy` are 0 right after reset.

Source files
------------

// File: rtl/word_packer.sv
// word_packer
//
// Packs a stream of IN_WIDTH-bit chunks into OUT_WIDTH-bit words, least
// significant chunk first, and emits each finished word with a one-cycle
// strobe. A flush emits a zero-padded partial word; a clear discards the
// partial word and realigns so the next chunk lands in slot 0.
//
// Handshake: there is no back-pressure. inclk is a one-cycle valid strobe
// qualifying in; every qualified chunk is accepted. outclk is a one-cycle
// valid strobe qualifying out/out_len, which then hold until the next emit.
//
// Ports
//   clk     : system clock
//   rst     : synchronous active-high reset
//   inclk   : chunk valid strobe
//   in      : chunk data
//   flush   : emit the current partial word, if any
//   clear   : drop the partial word and realign to chunk 0
//   outclk  : one-cycle emit strobe
//   out     : packed word, chunk k at [k*IN_WIDTH +: IN_WIDTH]
//   out_len : number of valid chunks in out (1..RATIO)
//   busy    : a partial word is held (also the observable EMPTY/PARTIAL state)
module word_packer #(
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 8,
  parameter int RATIO     = OUT_WIDTH / IN_WIDTH,
  parameter int CW        = $clog2(RATIO),
  parameter int LW        = $clog2(RATIO + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inclk,
  input  logic [IN_WIDTH-1:0]  in,
  input  logic                 flush,
  input  logic                 clear,
  output logic                 outclk,
  output logic [OUT_WIDTH-1:0] out,
  output logic [LW-1:0]        out_len,
  output logic                 busy
);

  logic [OUT_WIDTH-1:0] acc;
  logic [CW-1:0]        cnt;
  logic [OUT_WIDTH-1:0] acc_ins;   // acc with the incoming chunk placed at slot cnt
  logic                 last_slot;

  always_comb begin
    acc_ins = acc;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt == CW'(k)) acc_ins[k*IN_WIDTH +: IN_WIDTH] = in;
    end
  end

  assign last_slot = (cnt == CW'(RATIO - 1));

  // cnt is the state: zero is EMPTY, non-zero is PARTIAL.
  assign busy = (cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      outclk  <= 1'b0;
      out     <= '0;
      out_len <= '0;
    end else begin
      outclk <= 1'b0;
      if (clear) begin
        // flush is ignored here; a chunk arriving with clear starts a new word.
        if (inclk) begin
          acc <= {{(OUT_WIDTH-IN_WIDTH){1'b0}}, in};
          cnt <= CW'(1);
        end else begin
          acc <= '0;
          cnt <= '0;
        end
      end else if (inclk) begin
        if (last_slot || flush) begin
          // Chunk is accepted first, then exactly one emit covers it.
          outclk  <= 1'b1;
          out     <= acc_ins;
          out_len <= LW'(cnt) + LW'(1);
          acc     <= '0;
          cnt     <= '0;
        end else begin
          acc <= acc_ins;
          cnt <= cnt + CW'(1);
        end
      end else if (flush && busy) begin
        // Unfilled upper slots are already zero since acc is cleared per word.
        outclk  <= 1'b1;
        out     <= acc;
        out_len <= LW'(cnt);
        acc     <= '0;
        cnt     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_word_packer.sv
// tb_word_packer
//
// Directed bench for word_packer with IN_WIDTH=2, OUT_WIDTH=8. Expected
// words are pushed as {out_len, out} when the triggering stimulus is
// driven; a monitor pops and compares on every outclk pulse.
module tb_word_packer;

  localparam int IW = 2;
  localparam int OW = 8;
  localparam int LW = 3;
  localparam int W  = LW + OW;

  logic          clk;
  logic          rst;
  logic          inclk;
  logic [IW-1:0] in;
  logic          flush;
  logic          clear;
  logic          outclk;
  logic [OW-1:0] out;
  logic [LW-1:0] out_len;
  logic          busy;

  logic [W-1:0] exp_q[$];
  int checks;
  int errors;

  word_packer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk     (clk),
    .rst     (rst),
    .inclk   (inclk),
    .in      (in),
    .flush   (flush),
    .clear   (clear),
    .outclk  (outclk),
    .out     (out),
    .out_len (out_len),
    .busy    (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs applied, one rising edge taken, outputs sampled #1 later
  task automatic step(input logic v, input logic [IW-1:0] d, input logic f, input logic c);
    inclk = v;
    in    = d;
    flush = f;
    clear = c;
    @(posedge clk);
    #1;
    inclk = 1'b0;
    flush = 1'b0;
    clear = 1'b0;
  endtask

  task automatic chunk(input logic [IW-1:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [LW-1:0] len, input logic [OW-1:0] word);
    exp_q.push_back({len, word});
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every pulse must match the oldest expected word
  always @(negedge clk) begin
    if (!rst && outclk === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_emit observed=%0h expected=none", {out_len, out});
      end
      if (exp_q.size() != 0) begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        checks++;
        assert ({out_len, out} === e) else begin
          errors++;
          $error("FAIL emit_word observed=%0h expected=%0h", {out_len, out}, e);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; inclk = 1'b0; in = '0; flush = 1'b0; clear = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // reset state
    check("reset_outclk", 32'(outclk), 0);
    check("reset_out", 32'(out), 0);
    check("reset_len", 32'(out_len), 0);
    check("reset_busy", 32'(busy), 0);

    // full word 01,10,11,00 -> 0x39
    chunk(2'b01);
    check("full_busy_rise", 32'(busy), 1);
    chunk(2'b10);
    chunk(2'b11);
    chunk(2'b00);
    push(3'd4, 8'h39);
    check("full_outclk", 32'(outclk), 1);
    check("full_busy_fall", 32'(busy), 0);
    idle();
    check("full_pulse_width", 32'(outclk), 0);
    check("full_out_hold", 32'(out), 32'h39);

    // streaming 12 x 11
    for (int i = 0; i < 12; i++) begin
      chunk(2'b11);
      if (i % 4 == 3) push(3'd4, 8'hFF);
      check("stream_outclk", 32'(outclk), (i % 4 == 3) ? 1 : 0);
      check("stream_busy", 32'(busy), (i % 4 == 3) ? 0 : 1);
    end
    idle();

    // flush of a partial word 11,11,01 -> 0x1F len 3
    chunk(2'b11);
    chunk(2'b11);
    chunk(2'b01);
    step(1'b0, '0, 1'b1, 1'b0);
    push(3'd3, 8'h1F);
    check("flush_outclk", 32'(outclk), 1);
    check("flush_busy", 32'(busy), 0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("flush_empty_no_pulse", 32'(outclk), 0);
    check("flush_empty_out_hold", 32'(out), 32'h1F);
    check("flush_empty_len_hold", 32'(out_len), 3);

    // flush together with completing chunk -> 0x95 len 4, single pulse
    chunk(2'b01);
    chunk(2'b01);
    chunk(2'b01);
    step(1'b1, 2'b10, 1'b1, 1'b0);
    push(3'd4, 8'h95);
    check("flush_full_outclk", 32'(outclk), 1);
    idle();
    check("flush_full_single", 32'(outclk), 0);

    // flush with a single chunk -> len 1
    step(1'b1, 2'b10, 1'b1, 1'b0);
    push(3'd1, 8'h02);
    check("flush_one_outclk", 32'(outclk), 1);
    idle();

    // clear + inclk realigns: 11,11, clear+10, 00,00,00 -> 0x02 len 4
    chunk(2'b11);
    chunk(2'b11);
    step(1'b1, 2'b10, 1'b0, 1'b1);
    check("clear_in_no_pulse", 32'(outclk), 0);
    check("clear_in_busy", 32'(busy), 1);
    chunk(2'b00);
    chunk(2'b00);
    chunk(2'b00);
    push(3'd4, 8'h02);
    check("clear_word_outclk", 32'(outclk), 1);
    idle();

    // clear + flush without inclk: no pulse, partial dropped
    chunk(2'b11);
    step(1'b0, '0, 1'b1, 1'b1);
    check("clear_flush_no_pulse", 32'(outclk), 0);
    check("clear_flush_busy", 32'(busy), 0);
    idle();
    check("clear_flush_still_none", 32'(outclk), 0);
    check("clear_out_hold", 32'(out), 32'h02);

    // reset mid-word
    chunk(2'b11);
    chunk(2'b11);
    chunk(2'b11);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check("midrst_outclk", 32'(outclk), 0);
    check("midrst_out", 32'(out), 0);
    check("midrst_len", 32'(out_len), 0);
    check("midrst_busy", 32'(busy), 0);
    idle();
    check("midrst_no_emit", 32'(outclk), 0);
    for (int i = 0; i < 4; i++) chunk(2'b01);
    push(3'd4, 8'h55);
    check("midrst_word_outclk", 32'(outclk), 1);
    idle();
    idle();

    check("queue_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
